// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side line port (dfp_*) and banked-memory burst port (bmem_*)
interface cacheline_adapter_if #(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
);
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns 256-bit line reads/writes into 4-beat 64-bit bmem bursts; ADAPTER_POSTED_WRITE_EN acknowledges writes on the first beat
module cacheline_adapter #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4,
    parameter int LINE_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    cacheline_adapter_if.slave  bus
);
    localparam int CW = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BURST, RESP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [26:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              last;
    logic              hit;
    logic              unused_low_bits;

    assign last            = cnt == CW'(BEATS - 1);
    assign hit             = bus.bmem_rvalid && bus.bmem_raddr[31:5] == addr_q;
    assign bus.dfp_rdata   = rdata_q;
    assign unused_low_bits = ^{bus.dfp_addr[4:0], bus.bmem_raddr[4:0]};

`ifdef ADAPTER_POSTED_WRITE_EN
    logic wr_first;

    // marks the opening cycle of a write burst so the early acknowledge fires once
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wr_first <= 1'b0;
        else        wr_first <= state == IDLE && state_n == WR_BURST;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // next state and bus outputs; address/data only driven while a burst is active
    always_comb begin
        state_n         = state;
        bus.dfp_resp    = 1'b0;
        bus.bmem_read   = 1'b0;
        bus.bmem_write  = 1'b0;
        bus.bmem_addr   = '0;
        bus.bmem_wdata  = '0;
        case (state)
            IDLE:     state_n = bus.dfp_read ? RD_REQ : bus.dfp_write ? WR_BURST : IDLE;
            RD_REQ: begin
                bus.bmem_read = 1'b1;
                bus.bmem_addr = {addr_q, 5'b0};
                state_n       = bus.bmem_ready ? RD_DATA : RD_REQ;
            end
            RD_DATA:  state_n = hit && last ? RESP : RD_DATA;
            WR_BURST: begin
                bus.bmem_write = 1'b1;
                bus.bmem_addr  = {addr_q, 5'b0};
                bus.bmem_wdata = wdata_q[BEAT_W*int'(cnt) +: BEAT_W];
`ifdef ADAPTER_POSTED_WRITE_EN
                bus.dfp_resp   = wr_first;
                state_n        = bus.bmem_ready && last ? IDLE : WR_BURST;
`else
                state_n        = bus.bmem_ready && last ? RESP : WR_BURST;
`endif
            end
            RESP: begin
                bus.dfp_resp = 1'b1;
                state_n      = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    // request capture, beat counter and read-line assembly
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && (bus.dfp_read || bus.dfp_write)) begin
                addr_q  <= bus.dfp_addr[31:5];
                wdata_q <= bus.dfp_wdata;
            end
            if (state == RD_REQ) cnt <= '0;
            if (state == RD_DATA && hit) begin
                rdata_q[BEAT_W*int'(cnt) +: BEAT_W] <= bus.bmem_rdata;
                cnt <= cnt + CW'(1);
            end
            if (state == WR_BURST && bus.bmem_ready) cnt <= cnt + CW'(1);
        end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed checks of line read/write bursts, stray beats, reset abort and back-to-back traffic
module tb_cacheline_adapter;
`ifdef ADAPTER_POSTED_WRITE_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cacheline_adapter_if #(.BEAT_W(64), .LINE_W(256)) bus ();

    cacheline_adapter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_resp"},  256'(bus.dfp_resp),   256'(0));
        check({tag, "_rd"},    256'(bus.bmem_read),  256'(0));
        check({tag, "_wr"},    256'(bus.bmem_write), 256'(0));
        check({tag, "_addr"},  256'(bus.bmem_addr),  256'(0));
        check({tag, "_wdata"}, 256'(bus.bmem_wdata), 256'(0));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] b, input int stray, input int exp_wait);
        int w;
        int j;
        logic [255:0] line;
        bus.dfp_addr = a;
        bus.dfp_read = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (!bus.bmem_read && w < 10);
        check("rd_wait",  256'(w), 256'(exp_wait));
        check("rd_addr",  256'(bus.bmem_addr), 256'({a[31:5], 5'b0}));
        check("rd_no_wr", 256'(bus.bmem_write), 256'(0));
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        check("rd_req_once", 256'(bus.bmem_read), 256'(0));
        j = 0;
        line = '0;
        for (int k = 0; k < (stray >= 0 ? 5 : 4); k++) begin
            bus.bmem_rvalid = 1'b1;
            if (k == stray) begin
                bus.bmem_raddr = 32'h0000_3000;
                bus.bmem_rdata = 64'hDEAD_BEEF_0000_0000;
            end else begin
                bus.bmem_raddr = a;
                bus.bmem_rdata = b + 64'(j);
                line[j*64 +: 64] = b + 64'(j);
                j++;
            end
            check("rd_no_early_resp", 256'(bus.dfp_resp), 256'(0));
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        check("rd_resp", 256'(bus.dfp_resp), 256'(1));
        check("rd_line", bus.dfp_rdata, line);
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        tick();
        check("rd_resp_pulse", 256'(bus.dfp_resp), 256'(0));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int stall_beat,
                            input int stall_n, input logic rd_next, input logic [31:0] rd_addr);
        int resps;
        logic [63:0] bt;
        resps = 0;
        bus.dfp_addr  = a;
        bus.dfp_wdata = line;
        bus.dfp_write = 1'b1;
        tick();
        check("wr_first_resp", 256'(bus.dfp_resp), 256'(POSTED));
        for (int j = 0; j < 4; j++) begin
            bt = line[j*64 +: 64];
            for (int s = 0; s <= (j == stall_beat ? stall_n : 0); s++) begin
                bus.bmem_ready = (j != stall_beat) || (s == stall_n);
                check("wr_valid", 256'(bus.bmem_write), 256'(1));
                check("wr_addr",  256'(bus.bmem_addr),  256'({a[31:5], 5'b0}));
                check("wr_beat",  256'(bus.bmem_wdata), 256'(bt));
                check("wr_no_rd", 256'(bus.bmem_read),  256'(0));
                resps += int'(bus.dfp_resp);
                if (bus.dfp_resp) begin
                    bus.dfp_write = 1'b0;
                    if (rd_next) begin
                        bus.dfp_addr = rd_addr;
                        bus.dfp_read = 1'b1;
                    end
                end
                tick();
            end
        end
        bus.bmem_ready = 1'b0;
        check("wr_done", 256'(bus.bmem_write), 256'(0));
        check("wr_end_resp", 256'(bus.dfp_resp), 256'(!POSTED));
        resps += int'(bus.dfp_resp);
        bus.dfp_write = 1'b0;
        check("wr_resp_count", 256'(resps), 256'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_rdata", bus.dfp_rdata, 256'(0));
        rst_n = 1'b1;
        tick();
        check_quiet("idle");

        do_read(32'h0000_1040, 64'hA0, -1, 1);
        check("rd1_line", bus.dfp_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        do_write(32'h0000_2000, {64'h3, 64'h2, 64'h1, 64'h0}, 1, 3, 1'b0, 32'h0);
        tick();
        check("wr_idle_resp", 256'(bus.dfp_resp), 256'(0));
        check("rdata_stable", bus.dfp_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        bus.dfp_write = 1'b1;
        do_read(32'h0000_1040, 64'hB0, 1, 1);
        check("stray_line", bus.dfp_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});

        bus.dfp_addr = 32'h0000_1040;
        bus.dfp_read = 1'b1;
        tick();
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_1040;
        bus.bmem_rdata  = 64'hE0;
        tick();
        bus.bmem_rdata = 64'hE1;
        tick();
        rst_n = 1'b0;
        bus.dfp_read = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_rdata", bus.dfp_rdata, 256'(0));
        tick();
        rst_n = 1'b1;
        bus.bmem_rdata = 64'hE2;
        tick();
        check("late_resp", 256'(bus.dfp_resp), 256'(0));
        bus.bmem_rdata = 64'hE3;
        tick();
        bus.bmem_rvalid = 1'b0;
        check("late_resp2", 256'(bus.dfp_resp), 256'(0));
        check("late_rdata", bus.dfp_rdata, 256'(0));
        check("late_rd", 256'(bus.bmem_read), 256'(0));

        do_read(32'h0000_1040, 64'hF0, -1, 1);
        check("post_reset_line", bus.dfp_rdata, {64'hF3, 64'hF2, 64'hF1, 64'hF0});

        do_write(32'h0000_4000, {64'h13, 64'h12, 64'h11, 64'h10}, -1, 0, 1'b1, 32'h0000_8000);
        do_read(32'h0000_8000, 64'hC0, -1, POSTED ? 1 : 2);
        check("fill_line", bus.dfp_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
